// File: rtl/bc_turn_scheduler.sv
// ---------------------------------------------------------------------------
// bc_turn_scheduler
//   Turn controller for a two-player Bulls & Cows game. It accepts one guess
//   per turn from the current player and scores it serially against the
//   opponent's secret, one (secret nibble, guess nibble) pair per cycle. It
//   also enforces a per-turn tick timeout and a round limit that ends the
//   game in a draw.
//
// Ports
//   clock_i         system clock, rising edge
//   reset_ni        asynchronous active-low reset
//   start_i         1-cycle pulse, begins a game from IDLE or DONE
//   abort_i         synchronous return to IDLE, highest priority
//   tick_i          timebase strobe for the turn timer
//   secret1_i       P1 code, 4 BCD nibbles (stable while not IDLE)
//   secret2_i       P2 code, 4 BCD nibbles (stable while not IDLE)
//   guess_valid_i   current player offers a guess
//   guess_i         offered guess, 4 nibbles
//   guess_ready_o   high only while waiting for a guess
//   result_ack_i    consumer has read the result
//   result_valid_o  high only while a result is reported
//   bulls_o/cows_o  counts of the last scored guess
//   turn_o          current guesser, 0 = P1, 1 = P2
//   round_cnt_o     completed rounds (P1 + P2 turn pairs)
//   timeout_o       1-cycle pulse on a turn forfeit
//   game_over_o     high in DONE
//   winner_o        00 none, 01 P1, 10 P2, 11 draw
//   state_o         current FSM state, for observation
//
// Handshakes
//   Guess:  a guess transfers on a rising edge where guess_valid_i and
//           guess_ready_o are both high. guess_ready_o does not depend on
//           guess_valid_i.
//   Result: result_valid_o stays high, with bulls_o/cows_o stable, until a
//           rising edge where result_ack_i is high; that edge completes it.
// ---------------------------------------------------------------------------
module bc_turn_scheduler #(
    parameter int unsigned MAX_ROUNDS = 8,
    parameter int unsigned TURN_TICKS = 30
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        tick_i,
    input  logic [15:0] secret1_i,
    input  logic [15:0] secret2_i,
    input  logic        guess_valid_i,
    input  logic [15:0] guess_i,
    output logic        guess_ready_o,
    input  logic        result_ack_i,
    output logic        result_valid_o,
    output logic [2:0]  bulls_o,
    output logic [2:0]  cows_o,
    output logic        turn_o,
    output logic [3:0]  round_cnt_o,
    output logic        timeout_o,
    output logic        game_over_o,
    output logic [1:0]  winner_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_GUESS = 3'd1,
        S_SCORE      = 3'd2,
        S_REPORT     = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    // Timer only has to reach TURN_TICKS-1.
    localparam int TW = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [3:0]      idx_q;
    logic [15:0]     guess_q;
    logic            turn_q;
    logic [3:0]      round_cnt_q;
    logic [2:0]      bulls_q;
    logic [2:0]      cows_q;
    logic [1:0]      winner_q;
    logic            guess_ready_q;
    logic            result_valid_q;
    logic            timeout_q;
    logic            game_over_q;

    logic [15:0]     opp_secret_d;
    logic [3:0]      opp_nib_d;
    logic [3:0]      gss_nib_d;
    logic            match_d;
    logic            same_pos_d;
    logic            timer_last_d;
    logic [3:0]      rc_new_d;
    logic            draw_d;

    // The guesser is scored against the other player's secret.
    assign opp_secret_d = turn_q ? secret1_i : secret2_i;

    // idx[3:2] walks the secret nibbles, idx[1:0] the guess nibbles, so all
    // 16 pairs are visited; equal positions are bulls, the rest are cows.
    assign opp_nib_d  = 4'(opp_secret_d >> {idx_q[3:2], 2'b00});
    assign gss_nib_d  = 4'(guess_q >> {idx_q[1:0], 2'b00});
    assign match_d    = (opp_nib_d == gss_nib_d);
    assign same_pos_d = (idx_q[3:2] == idx_q[1:0]);

    assign timer_last_d = (timer_q == TW'(TURN_TICKS - 1));

    // Turn switch: a round completes when P2's turn ends.
    assign rc_new_d = turn_q ? (round_cnt_q + 4'd1) : round_cnt_q;
    assign draw_d   = (rc_new_d == 4'(MAX_ROUNDS));

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            idx_q          <= '0;
            guess_q        <= '0;
            turn_q         <= 1'b0;
            round_cnt_q    <= '0;
            bulls_q        <= '0;
            cows_q         <= '0;
            winner_q       <= '0;
            guess_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (abort_i) begin
                state_q        <= S_IDLE;
                timer_q        <= '0;
                idx_q          <= '0;
                turn_q         <= 1'b0;
                round_cnt_q    <= '0;
                bulls_q        <= '0;
                cows_q         <= '0;
                winner_q       <= '0;
                guess_ready_q  <= 1'b0;
                result_valid_q <= 1'b0;
                game_over_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_i) begin
                            state_q       <= S_WAIT_GUESS;
                            turn_q        <= 1'b0;
                            round_cnt_q   <= '0;
                            timer_q       <= '0;
                            winner_q      <= '0;
                            guess_ready_q <= 1'b1;
                            game_over_q   <= 1'b0;
                        end
                    end

                    S_WAIT_GUESS: begin
                        // A guess arriving with the expiring tick still wins.
                        if (guess_valid_i) begin
                            state_q       <= S_SCORE;
                            guess_q       <= guess_i;
                            timer_q       <= '0;
                            idx_q         <= '0;
                            bulls_q       <= '0;
                            cows_q        <= '0;
                            guess_ready_q <= 1'b0;
                        end else if (tick_i) begin
                            if (timer_last_d) begin
                                // Forfeit: switch turns without a report.
                                timeout_q   <= 1'b1;
                                timer_q     <= '0;
                                round_cnt_q <= rc_new_d;
                                if (draw_d) begin
                                    state_q       <= S_DONE;
                                    winner_q      <= 2'b11;
                                    guess_ready_q <= 1'b0;
                                    game_over_q   <= 1'b1;
                                end else begin
                                    turn_q <= ~turn_q;
                                end
                            end else begin
                                timer_q <= timer_q + TW'(1);
                            end
                        end
                    end

                    S_SCORE: begin
                        if (match_d) begin
                            if (same_pos_d) begin
                                bulls_q <= (bulls_q == 3'd7) ? bulls_q : bulls_q + 3'd1;
                            end else begin
                                cows_q <= (cows_q == 3'd7) ? cows_q : cows_q + 3'd1;
                            end
                        end
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_q        <= S_REPORT;
                            result_valid_q <= 1'b1;
                        end
                    end

                    S_REPORT: begin
                        if (result_ack_i) begin
                            result_valid_q <= 1'b0;
                            if (bulls_q == 3'd4) begin
                                // The guesser cracked the code: P1 -> 01, P2 -> 10.
                                state_q     <= S_DONE;
                                winner_q    <= {turn_q, ~turn_q};
                                game_over_q <= 1'b1;
                            end else begin
                                round_cnt_q <= rc_new_d;
                                if (draw_d) begin
                                    state_q     <= S_DONE;
                                    winner_q    <= 2'b11;
                                    game_over_q <= 1'b1;
                                end else begin
                                    state_q       <= S_WAIT_GUESS;
                                    turn_q        <= ~turn_q;
                                    timer_q       <= '0;
                                    guess_ready_q <= 1'b1;
                                end
                            end
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign guess_ready_o  = guess_ready_q;
    assign result_valid_o = result_valid_q;
    assign bulls_o        = bulls_q;
    assign cows_o         = cows_q;
    assign turn_o         = turn_q;
    assign round_cnt_o    = round_cnt_q;
    assign timeout_o      = timeout_q;
    assign game_over_o    = game_over_q;
    assign winner_o       = winner_q;
    assign state_o        = state_q;

endmodule
